// File: rtl/my_ram_banked.sv
// Banked word RAM with registered read, valid flag and a zero-fill clear sequencer.
// Optional feature: define MY_RAM_PARITY_EN to store an even-parity bit per word.
module my_ram_banked #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned BANK_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 load,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  output logic                 busy
`ifdef MY_RAM_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned Banks      = 2 ** BANK_BITS;
  localparam int unsigned LocalBits  = ADDR_BITS - BANK_BITS;
  localparam int unsigned LocalDepth = 2 ** LocalBits;
`ifdef MY_RAM_PARITY_EN
  localparam int unsigned SW = WIDTH + 1;
`else
  localparam int unsigned SW = WIDTH;
`endif
  localparam logic [ADDR_BITS-1:0] LastAddr = '1;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   ctr_q, ctr_d;
  logic                   valid_q;
  logic [BANK_BITS-1:0]   sel_q;

  logic                   wr_en, rd_en;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [SW-1:0]          wr_data, load_word;
  logic [BANK_BITS-1:0]   wr_bank, rd_bank;
  logic [LocalBits-1:0]   wr_local, rd_local;
  logic [SW-1:0]          bank_rd [Banks];
  logic [SW-1:0]          sel_word;

`ifdef MY_RAM_PARITY_EN
  assign load_word = {^in, in};
`else
  assign load_word = in;
`endif

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = addr;
    wr_data = load_word;
    unique case (state_q)
      StClear: begin
        wr_en   = 1'b1;
        wr_addr = ctr_q;
        wr_data = '0;
        if (clear) begin
          ctr_d = '0;
        end else if (ctr_q == LastAddr) begin
          state_d = StIdle;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      StIdle: begin
        if (clear) begin
          // The clear edge neither writes nor reads, so out_valid stays low while busy.
          state_d = StClear;
          ctr_d   = '0;
        end else begin
          wr_en = load;
          rd_en = 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  assign busy     = (state_q == StClear);
  assign wr_bank  = wr_addr[ADDR_BITS-1 -: BANK_BITS];
  assign wr_local = wr_addr[LocalBits-1:0];
  assign rd_bank  = addr[ADDR_BITS-1 -: BANK_BITS];
  assign rd_local = addr[LocalBits-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      ctr_q   <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      valid_q <= rd_en;
      if (rd_en) sel_q <= rd_bank;
    end
  end

  for (genvar b = 0; b < Banks; b++) begin : g_bank
    logic [SW-1:0] mem [LocalDepth];
    logic [SW-1:0] rd_q;

    // Only the addressed bank is enabled; read-first on a same-address write.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_bank == BANK_BITS'(b))) mem[wr_local] <= wr_data;
      if (rd_en && (rd_bank == BANK_BITS'(b))) rd_q <= mem[rd_local];
    end

    assign bank_rd[b] = rd_q;
  end

  assign sel_word  = bank_rd[sel_q];
  assign out       = valid_q ? sel_word[WIDTH-1:0] : '0;
  assign out_valid = valid_q;
`ifdef MY_RAM_PARITY_EN
  assign parity_err = valid_q & (^sel_word);
`endif

endmodule

// File: tb/tb_my_ram_banked.sv
// Self-checking bench for my_ram_banked: behavioural model plus directed literal checks.
module tb_my_ram_banked;

  localparam int Depth = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = '0;
  logic [8:0]  addr = '0;
  logic        load = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;
`ifdef MY_RAM_PARITY_EN
  logic        parity_err;
`endif

  my_ram_banked #(.WIDTH(16), .ADDR_BITS(9), .BANK_BITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .addr      (addr),
    .load      (load),
    .clear     (clear),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
`ifdef MY_RAM_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic started = 1'b0;
  logic skip_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: remaining sweep cycles, word array, and last read result.
  int          m_left = Depth;
  logic [15:0] m_mem [Depth];
  logic [15:0] m_out = '0;
  logic        m_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= Depth;
      m_valid <= 1'b0;
      m_out   <= '0;
    end else if (m_left > 0) begin
      m_valid <= 1'b0;
      if (clear) m_left <= Depth;
      else begin
        m_left <= m_left - 1;
        if (m_left == 1) for (int i = 0; i < Depth; i++) m_mem[i] <= '0;
      end
    end else if (clear) begin
      m_left  <= Depth;
      m_valid <= 1'b0;
    end else begin
      m_out   <= m_mem[addr];
      m_valid <= 1'b1;
      if (load) m_mem[addr] <= in;
    end
  end

  always @(negedge clk) begin
    if (started && !skip_cmp) begin
      check("busy", {31'd0, busy}, {31'd0, m_left != 0});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("out", {16'd0, out}, m_valid ? {16'd0, m_out} : 32'd0);
`ifdef MY_RAM_PARITY_EN
      check("parity_err", {31'd0, parity_err}, 32'd0);
`endif
    end
  end

  task automatic cyc(input logic ld, input logic clr, input logic [8:0] a, input logic [15:0] d);
    load  = ld;
    clear = clr;
    addr  = a;
    in    = d;
    @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    load  = 1'b0;
    clear = 1'b0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic read_expect(input string name, input logic [8:0] a, input logic [15:0] exp);
    cyc(1'b0, 1'b0, a, 16'h0);
    check(name, {16'd0, out}, {16'd0, exp});
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", {16'd0, out}, 32'd0);
    wait_idle(n);
    check("sweep_len_reset", n, 512);

    for (int i = 0; i < Depth; i++) cyc(1'b0, 1'b0, 9'(i), 16'h0);
    read_expect("zero_1ff", 9'h1FF, 16'h0000);

    cyc(1'b1, 1'b0, 9'h000, 16'hBEEF);
    cyc(1'b1, 1'b0, 9'h1FF, 16'h1234);
    cyc(1'b1, 1'b0, 9'h040, 16'hA5A5);
    read_expect("rd_000", 9'h000, 16'hBEEF);
    read_expect("rd_1ff", 9'h1FF, 16'h1234);
    read_expect("rd_040", 9'h040, 16'hA5A5);
    read_expect("rd_001", 9'h001, 16'h0000);
    read_expect("rd_03f", 9'h03F, 16'h0000);
    check("valid_idle", {31'd0, out_valid}, 32'd1);

    cyc(1'b1, 1'b0, 9'h0C0, 16'h1111);
    cyc(1'b1, 1'b0, 9'h0C0, 16'h5555);
    check("read_first_old", {16'd0, out}, 32'h1111);
    read_expect("read_first_new", 9'h0C0, 16'h5555);

    // Reset during an access: outputs drop at once.
    read_expect("pre_rst_read", 9'h000, 16'hBEEF);
    #1 rst_n = 1'b0;
    #1;
    check("rst_access_out", {16'd0, out}, 32'd0);
    check("rst_access_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(n);
    check("sweep_len_rst_access", n, 512);

    cyc(1'b1, 1'b0, 9'h0C0, 16'h7777);
    cyc(1'b1, 1'b1, 9'h0C0, 16'h9999);
    check("clear_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("sweep_len_clear", n, 512);
    read_expect("clear_dropped_write", 9'h0C0, 16'h0000);

    cyc(1'b0, 1'b1, 9'h0, 16'h0);
    repeat (99) cyc(1'b0, 1'b0, 9'h0, 16'h0);
    cyc(1'b0, 1'b1, 9'h0, 16'h0);
    wait_idle(n);
    check("sweep_len_double_clear", 100 + n, 612);

    cyc(1'b0, 1'b1, 9'h0, 16'h0);
    repeat (199) cyc(1'b0, 1'b0, 9'h0, 16'h0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_sweep_out", {16'd0, out}, 32'd0);
    check("rst_sweep_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(n);
    check("sweep_len_rst_sweep", n, 512);

`ifdef MY_RAM_PARITY_EN
    cyc(1'b1, 1'b0, 9'h010, 16'h00FF);
    read_expect("par_clean_data", 9'h010, 16'h00FF);
    check("par_clean", {31'd0, parity_err}, 32'd0);
    skip_cmp = 1'b1;
    dut.g_bank[0].mem[16] = dut.g_bank[0].mem[16] ^ 17'h00001;
    read_expect("par_flip_data", 9'h010, 16'h00FE);
    check("par_flip_err", {31'd0, parity_err}, 32'd1);
    dut.g_bank[0].mem[16] = dut.g_bank[0].mem[16] ^ 17'h00001;
    read_expect("par_restored", 9'h010, 16'h00FF);
    skip_cmp = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [8:0] a;
      a = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 599) == 0), a, 16'($urandom));
    end
    wait_idle(n);
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
